clk_div_cfg_ctrl: RTL and testbench



---
 rtl/clk_div_cfg_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// Ratio-change controller for the programmable clock divider: round-robin between two
// requesters, then gate / settle / load / re-enable / lock-check before acknowledging.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | divider running; arbitrate requests, reject 0 / ack no-op
// GATE   | divider enable held low for SETTLE_CYC cycles
// LOAD   | new ratio driven to the divider while still gated
// ENABLE | divider re-enabled; bypass ratios skip the lock check
// LOCK   | wait for a synchronised rising edge of the divided clock
// DONE   | issue the ack for the granted requester
module clk_div_cfg_ctrl #(
    parameter int RATIO_W      = 5,
    parameter int SETTLE_CYC   = 2,
    parameter int LOCK_TIMEOUT = 64,
    parameter int RESET_RATIO  = 1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_req,
    input  logic [RATIO_W-1:0] i_ratio_0,
    input  logic [RATIO_W-1:0] i_ratio_1,
    input  logic               i_div_clk,
    output logic               o_clk_en,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic [1:0]         o_ack,
    output logic [1:0]         o_err,
    output logic               o_busy
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int LCK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [SET_W-1:0]   SET_LOAD  = SET_W'(SETTLE_CYC - 1);
    localparam logic [LCK_W-1:0]   LCK_LOAD  = LCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ENABLE = 3'd3,
        ST_LOCK   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_rr;
    logic [RATIO_W-1:0] r_stage_ratio;
    logic               r_stage_id;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [LCK_W-1:0]   r_lock_cnt;
    logic               r_clk_en;
    logic [RATIO_W-1:0] r_div_ratio;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;
    logic               r_busy;
    logic               r_dclk_meta;
    logic               r_dclk_sync;
    logic               r_dclk_prev;

    state_t             w_state_nxt;
    logic               w_rr_nxt;
    logic [RATIO_W-1:0] w_stage_ratio_nxt;
    logic               w_stage_id_nxt;
    logic [SET_W-1:0]   w_settle_nxt;
    logic [LCK_W-1:0]   w_lock_nxt;
    logic               w_clk_en_nxt;
    logic [RATIO_W-1:0] w_ratio_nxt;
    logic [1:0]         w_ack_nxt;
    logic [1:0]         w_err_nxt;

    logic               w_both;
    logic               w_gnt_id;
    logic [RATIO_W-1:0] w_gnt_ratio;
    logic               w_arb_ok;
    logic               w_lock_edge;

    // Requests are held until their pulse is seen, so no arbitration while a pulse is out.
    assign w_both      = i_req[0] & i_req[1];
    assign w_gnt_id    = w_both ? r_rr : i_req[1];
    assign w_gnt_ratio = w_gnt_id ? i_ratio_1 : i_ratio_0;
    assign w_arb_ok    = (r_state == ST_IDLE) && (i_req != 2'b00) && ((r_ack | r_err) == 2'b00);
    assign w_lock_edge = r_dclk_sync & ~r_dclk_prev;

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_nxt          = r_rr;
        w_stage_ratio_nxt = r_stage_ratio;
        w_stage_id_nxt    = r_stage_id;
        w_settle_nxt      = r_settle_cnt;
        w_lock_nxt        = r_lock_cnt;
        w_clk_en_nxt      = r_clk_en;
        w_ratio_nxt       = r_div_ratio;
        w_ack_nxt         = 2'b00;
        w_err_nxt         = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_ok) begin
                    w_stage_ratio_nxt = w_gnt_ratio;
                    w_stage_id_nxt    = w_gnt_id;
                    if (w_both) begin
                        w_rr_nxt = ~w_gnt_id;
                    end
                    if (w_gnt_ratio == '0) begin
                        w_err_nxt[w_gnt_id] = 1'b1;
                    end else if (w_gnt_ratio == r_div_ratio) begin
                        w_ack_nxt[w_gnt_id] = 1'b1;
                    end else begin
                        w_state_nxt  = ST_GATE;
                        w_clk_en_nxt = 1'b0;
                        w_settle_nxt = SET_LOAD;
                    end
                end
            end
            ST_GATE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_settle_nxt = r_settle_cnt - SET_W'(1);
                end
            end
            ST_LOAD: begin
                w_ratio_nxt = r_stage_ratio;
                w_state_nxt = ST_ENABLE;
            end
            ST_ENABLE: begin
                w_clk_en_nxt = 1'b1;
                // Ratio 0/1 puts the divider in bypass, so there is no edge to wait for.
                if (r_stage_ratio <= RATIO_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LOCK;
                    w_lock_nxt  = LCK_LOAD;
                end
            end
            ST_LOCK: begin
                if (w_lock_edge) begin
                    w_state_nxt = ST_DONE;
                end else if (r_lock_cnt == '0) begin
                    w_err_nxt[r_stage_id] = 1'b1;
                    w_state_nxt           = ST_IDLE;
                end else begin
                    w_lock_nxt = r_lock_cnt - LCK_W'(1);
                end
            end
            ST_DONE: begin
                w_ack_nxt[r_stage_id] = 1'b1;
                w_state_nxt           = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_rr          <= 1'b0;
            r_stage_ratio <= '0;
            r_stage_id    <= 1'b0;
            r_settle_cnt  <= '0;
            r_lock_cnt    <= '0;
            r_clk_en      <= 1'b1;
            r_div_ratio   <= RST_RATIO;
            r_ack         <= 2'b00;
            r_err         <= 2'b00;
            r_busy        <= 1'b0;
            r_dclk_meta   <= 1'b0;
            r_dclk_sync   <= 1'b0;
            r_dclk_prev   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr          <= w_rr_nxt;
            r_stage_ratio <= w_stage_ratio_nxt;
            r_stage_id    <= w_stage_id_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_lock_cnt    <= w_lock_nxt;
            r_clk_en      <= w_clk_en_nxt;
            r_div_ratio   <= w_ratio_nxt;
            r_ack         <= w_ack_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_dclk_meta   <= i_div_clk;
            r_dclk_sync   <= r_dclk_meta;
            r_dclk_prev   <= r_dclk_sync;
        end
    end

    assign o_clk_en    = r_clk_en;
    assign o_div_ratio = r_div_ratio;
    assign o_ack       = r_ack;
    assign o_err       = r_err;
    assign o_busy      = r_busy;

    a_no_ack_err_overlap : assert property (@(posedge i_ref_clk) disable iff (i_rst)
        (r_ack & r_err) == 2'b00);
    a_gated_only_when_busy : assert property (@(posedge i_ref_clk) disable iff (i_rst)
        !r_clk_en |-> r_busy);

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: directed request sequences, a time-since-grant reference
// model compared every cycle, and literal checks on latencies and final settings.
module tb_clk_div_cfg_ctrl;

    localparam int RATIO_W = 5;
    localparam int S       = 2;
    localparam int LT      = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req = 2'b00;
    logic [RATIO_W-1:0] ratio0 = '0;
    logic [RATIO_W-1:0] ratio1 = '0;
    logic               div_clk = 1'b0;
    logic               o_clk_en;
    logic [RATIO_W-1:0] o_div_ratio;
    logic [1:0]         o_ack;
    logic [1:0]         o_err;
    logic               o_busy;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    bit hold_low = 1'b0;
    int dcnt = 0;

    clk_div_cfg_ctrl #(.RATIO_W(RATIO_W), .SETTLE_CYC(S), .LOCK_TIMEOUT(LT), .RESET_RATIO(1)) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_ratio_0  (ratio0),
        .i_ratio_1  (ratio1),
        .i_div_clk  (div_clk),
        .o_clk_en   (o_clk_en),
        .o_div_ratio(o_div_ratio),
        .o_ack      (o_ack),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: counts while enabled, high for the back half of each period.
    always @(negedge clk) begin
        if (rst || !o_clk_en || int'(o_div_ratio) <= 1 || hold_low) begin
            dcnt    = 0;
            div_clk = 1'b0;
        end else begin
            dcnt    = (dcnt + 1 >= int'(o_div_ratio)) ? 0 : dcnt + 1;
            div_clk = (dcnt >= int'(o_div_ratio) / 2);
        end
    end

    // Reference model: timeline measured in edges since the grant edge (t = 0).
    bit       m_en;
    int       m_ratio;
    bit [1:0] m_ack, m_err;
    bit       m_busy, m_rr;
    int       m_t, m_tgt, m_id, m_done_at, m_gid, m_r;
    bit       m_pulsed;
    bit       v [0:255];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = 1'b1; m_ratio = 1; m_ack = 2'b00; m_err = 2'b00;
            m_busy = 1'b0; m_rr = 1'b0; m_t = -1; m_done_at = -1;
        end else begin
            m_pulsed = ((m_ack | m_err) != 2'b00);
            m_ack = 2'b00;
            m_err = 2'b00;
            if (m_t < 0) begin
                if (!m_pulsed && req != 2'b00) begin
                    m_gid = (req == 2'b11) ? int'(m_rr) : int'(req[1]);
                    if (req == 2'b11) m_rr = !m_rr;
                    m_r = (m_gid == 1) ? int'(ratio1) : int'(ratio0);
                    if (m_r == 0) m_err[m_gid] = 1'b1;
                    else if (m_r == m_ratio) m_ack[m_gid] = 1'b1;
                    else begin
                        m_t = 0; m_tgt = m_r; m_id = m_gid;
                        m_en = 1'b0; m_busy = 1'b1; v[0] = div_clk;
                        m_done_at = (m_r <= 1) ? S + 3 : -1;
                    end
                end
            end else begin
                m_t++;
                v[m_t] = div_clk;
                if (m_t == S + 1) m_ratio = m_tgt;
                if (m_t == S + 2) m_en = 1'b1;
                if (m_done_at < 0) begin
                    if (m_t >= S + 3) begin
                        // a rise seen at edge j is visible to the lock check two edges later
                        if (v[m_t-2] && !v[m_t-3]) m_done_at = m_t + 1;
                        else if (m_t == S + 2 + LT) begin
                            m_err[m_id] = 1'b1; m_busy = 1'b0; m_t = -1;
                        end
                    end
                end else if (m_t == m_done_at) begin
                    m_ack[m_id] = 1'b1; m_busy = 1'b0; m_t = -1; m_done_at = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_clk_en", 32'(o_clk_en), 32'(m_en));
            chk("model_div_ratio", 32'(o_div_ratio), 32'(m_ratio));
            chk("model_ack", 32'(o_ack), 32'(m_ack));
            chk("model_err", 32'(o_err), 32'(m_err));
            chk("model_busy", 32'(o_busy), 32'(m_busy));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_any(output logic [1:0] ack, output logic [1:0] err);
        int cyc;
        ack = 2'b00; err = 2'b00; cyc = 0;
        while (cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if ((o_ack | o_err) != 2'b00) begin
                ack = o_ack; err = o_err;
                break;
            end
        end
        chk("pulse_within_budget", 32'((ack | err) != 2'b00), 32'd1);
    endtask

    task automatic run_req(input int id, input int ratio, output int cyc, output int en_low,
                           output bit gated_ratio, output int rise_cyc,
                           output logic [1:0] ack, output logic [1:0] err);
        bit en_back;
        logic prev_div;
        step(1);
        if (id == 0) ratio0 = RATIO_W'(ratio); else ratio1 = RATIO_W'(ratio);
        req[id] = 1'b1;
        cyc = 0; en_low = 0; gated_ratio = 1'b0; rise_cyc = -1;
        ack = 2'b00; err = 2'b00; en_back = 1'b0; prev_div = div_clk;
        while (cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if (!o_clk_en) begin
                en_low++;
                if (int'(o_div_ratio) == ratio) gated_ratio = 1'b1;
            end else if (en_low > 0) en_back = 1'b1;
            if (en_back && rise_cyc < 0 && div_clk && !prev_div) rise_cyc = cyc;
            prev_div = div_clk;
            if ((o_ack | o_err) != 2'b00) begin
                ack = o_ack; err = o_err;
                break;
            end
        end
        req[id] = 1'b0;
        chk("pulse_within_budget", 32'((ack | err) != 2'b00), 32'd1);
    endtask

    initial begin
        int cyc, en_low, rise;
        bit gr, seen;
        logic [1:0] a, e;

        @(posedge clk); #1;
        chk_on = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        chk("rst_clk_en", 32'(o_clk_en), 32'd1);
        chk("rst_ratio", 32'(o_div_ratio), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        // ratio 4: gated 4 cycles, ratio visible while gated, ack shortly after first rise
        run_req(0, 4, cyc, en_low, gr, rise, a, e);
        chk("r4_ack", 32'(a), 32'd1);
        chk("r4_en_low_cycles", 32'(en_low), 32'(S + 2));
        chk("r4_ratio_while_gated", 32'(gr), 32'd1);
        chk("r4_ack_after_rise", 32'(rise > 0 && (cyc - rise) <= 4), 32'd1);

        // contention after reset: rr starts at 0
        step(1);
        ratio0 = 5'd3; ratio1 = 5'd6; req = 2'b11;
        wait_any(a, e);
        chk("rr1_first_ack", 32'(a), 32'd1);
        req[0] = 1'b0;
        wait_any(a, e);
        chk("rr1_second_ack", 32'(a), 32'd2);
        req[1] = 1'b0;
        chk("rr1_ratio", 32'(o_div_ratio), 32'd6);

        step(1);
        ratio0 = 5'd6; ratio1 = 5'd3; req = 2'b11;
        wait_any(a, e);
        chk("rr2_first_ack", 32'(a), 32'd2);
        req[1] = 1'b0;
        wait_any(a, e);
        chk("rr2_second_ack", 32'(a), 32'd1);
        req[0] = 1'b0;
        chk("rr2_ratio", 32'(o_div_ratio), 32'd6);

        run_req(1, 0, cyc, en_low, gr, rise, a, e);
        chk("zero_err", 32'(e), 32'd2);
        chk("zero_latency", 32'(cyc), 32'd1);
        chk("zero_no_gate", 32'(en_low), 32'd0);
        chk("zero_ratio_kept", 32'(o_div_ratio), 32'd6);

        run_req(0, 6, cyc, en_low, gr, rise, a, e);
        chk("same_ack", 32'(a), 32'd1);
        chk("same_latency", 32'(cyc), 32'd1);
        chk("same_no_gate", 32'(en_low), 32'd0);

        run_req(1, 1, cyc, en_low, gr, rise, a, e);
        chk("bypass_ack", 32'(a), 32'd2);
        chk("bypass_latency", 32'(cyc), 32'(S + 4));
        chk("bypass_en_low", 32'(en_low), 32'(S + 2));

        hold_low = 1'b1;
        run_req(0, 5, cyc, en_low, gr, rise, a, e);
        chk("timeout_err", 32'(e), 32'd1);
        chk("timeout_no_ack", 32'(a), 32'd0);
        chk("timeout_latency", 32'(cyc), 32'(S + 3 + LT));
        chk("timeout_ratio", 32'(o_div_ratio), 32'd5);
        chk("timeout_clk_en", 32'(o_clk_en), 32'd1);
        hold_low = 1'b0;

        // async reset while gated
        step(1);
        ratio0 = 5'd7; req = 2'b01;
        step(1);
        chk("gate_clk_en", 32'(o_clk_en), 32'd0);
        chk("gate_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_clk_en", 32'(o_clk_en), 32'd1);
        chk("async_rst_ratio", 32'(o_div_ratio), 32'd1);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        req = 2'b00;
        step(2);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            step(1);
            if ((o_ack | o_err) != 2'b00) seen = 1'b1;
        end
        chk("no_pulse_after_rst", 32'(seen), 32'd0);
        chk("post_rst_ratio", 32'(o_div_ratio), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
